lsoc1000_stage_iq: RTL
======================

# lsoc1000_stage_iq

3-wide instruction queue between fetch and de1. Buffers up to three fetched instructions per cycle with their predecode and exception metadata in a circular queue. Presents the oldest three in program order on the de1 ports. Decouples fetch from decode backpressure and drops everything on a pipeline flush.

## Interface
- `QDEPTH`, 8: queue entries. Must be a power of two and ≥ 4.
- `clk` in 1: clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `flush` in 1: discard all queued entries and this cycle's fetch packet.
- `allow_in` in 1: de1 accepts the presented instructions this cycle.
- `fe_port{k}_valid` in 1 (k=0..2): fetch slot k holds an instruction. Port 0 is the oldest.
- `fe_port{k}_pc` in `GRLEN`; `fe_port{k}_inst` in 32; `fe_port{k}_br_target` in `GRLEN-2`; `fe_port{k}_br_taken` in 1; `fe_port{k}_exception` in 1; `fe_port{k}_exccode` in 6; `fe_port{k}_hint` in `LSOC1K_PRU_HINT+1`: slot payload.
- `fe_allow_in` out 1: queue can take a full 3-instruction packet this cycle.
- `de1_port{k}_valid` out 1 (k=0..2): queue entry head+k is presented.
- `de1_port{k}_pc`, `_inst`, `_br_target`, `_br_taken`, `_exception`, `_exccode`, `_hint` out: same widths as the fe fields. Payload of entry head+k.

## Operation
- **State:** entry array `[QDEPTH]` holding the 7 payload fields, `head` ptr, `tail` ptr (log2(QDEPTH) bits each, wrap modulo QDEPTH), `count` (log2(QDEPTH)+1 bits, 0..QDEPTH).
- **Enqueue count `n_in`:** length of the contiguous valid prefix starting at port 0.
  - Patterns 000/001/011/111 give 0/1/2/3.
  - Slots after the first invalid slot are ignored (e.g. 101 gives 1).
- **Enqueue:** happens when `fe_allow_in & !flush`. Slot j is written to entry `(tail+j) mod QDEPTH` for j < `n_in`, and `tail` advances by `n_in`.
- **`fe_allow_in`:** `(QDEPTH - count) >= 3`. It depends only on registered `count`, never on `allow_in` or `flush`.
- **Presentation:**
  - `de1_port{k}_valid = (count > k) & !flush`.
  - Payload = entry `(head+k) mod QDEPTH`, muxed combinationally from the array.
  - Payload is driven even when the port is not valid.
- **Dequeue count `n_out`:** `allow_in & !flush ? min(count,3) : 0`. `head` advances by `n_out`.
- **Simultaneous enqueue and dequeue:** `count_next = count + n_in_eff - n_out`. Dequeue never reads an entry written in the same cycle, because writes target `tail` and newer positions.
- **Flush:** has priority over everything.
  - Next cycle: `head = tail = count = 0`.
  - The fetch packet in the flush cycle is dropped.
  - Entry contents are not cleared.
- **Ordering invariant:** de1 port 0 always carries the oldest outstanding instruction. Valid ports are always a contiguous prefix (`valid1` implies `valid0`, `valid2` implies `valid1`).
- The queue never overflows. `count` stays ≤ QDEPTH under any legal stimulus, because enqueue is gated by `fe_allow_in`.

## Timing
- **Reset (async assert, `resetn` low):**
  - `head = tail = count = 0`; all entries zeroed.
  - All `de1_port{k}_valid = 0` and all de1 payload outputs = 0.
  - `fe_allow_in = 1`.
- **Latency:** an instruction enqueued at edge N is presented on de1 ports in the cycle after edge N (1-cycle fetch-to-decode latency). There is no same-cycle bypass.
- **Empty:** all de1 valids = 0. `allow_in` has no effect.
- **Near full:** with `count = QDEPTH-2`, `fe_allow_in = 0` even if fetch offers only 1 instruction.
- **Full:** with `count = QDEPTH`, `fe_allow_in = 0`. Dequeue proceeds normally.
- **Wrap-around:** `head+k` and `tail+j` wrap modulo QDEPTH, so a packet may straddle entry QDEPTH-1 and entry 0.
- **Reset mid-operation:** queue empties immediately (asynchronously). The first enqueue after deassertion lands in entry 0.
- **Flush concurrent with `allow_in`:** nothing is reported as accepted, because valids are forced low in that cycle.

## Test plan
1. **Reset:** reset, then release with no fetch → all de1 valids 0, `fe_allow_in`=1, count 0. Assert `resetn` low mid-stream with count 5 → valids 0 in the same cycle.
2. **Single packet:** fetch pc 0x1000/0x1004/0x1008 (valid 111) with `allow_in`=0 → next cycle de1 ports 0..2 show 0x1000/0x1004/0x1008, count 3. Raise `allow_in` → count 0 the following cycle.
3. **Partial packet and prefix rule:** fetch pattern 011, then 101 → count 3. Port 2 carries slot 0 of the second packet; its slot 2 is never presented.
4. **Backpressure and full:** hold `allow_in`=0 and stream full packets (QDEPTH=8) → `fe_allow_in` drops after the 2nd packet (count 6). A single-instruction fetch is also refused. Release `allow_in` → order is preserved across the stall.
5. **Wrap with simultaneous enqueue/dequeue:** continuous 3-in/3-out for 20 cycles with sequential pcs → de1 pcs strictly sequential, count constant at 3, pointers wrap without gaps.
6. **Flush:** with count 5 and a fetch packet valid, assert `flush` → valids 0 that cycle. Next cycle count 0, and the packet from the flush cycle never appears. An enqueue the cycle after the flush appears normally.

Source files
------------

// File: rtl/lsoc1000_stage_iq_if.sv
// ---------------------------------------------------------------------------
// lsoc1000_stage_iq_if
// A 3-wide instruction bundle between two pipeline stages. Slot 0 is the
// oldest instruction of the bundle.
//   master : drives valid and the per-slot payload, samples ready
//   slave  : samples valid and the payload, drives ready
//   valid[k]     slot k holds an instruction
//   pc[k]        instruction address
//   inst[k]      instruction word
//   br_target[k] predicted branch target (word address)
//   br_taken[k]  predicted taken
//   exception[k] fetch-side exception flag
//   exccode[k]   exception code
//   hint[k]      predecode hint
//   ready        downstream can accept the bundle this cycle
// ---------------------------------------------------------------------------
interface lsoc1000_stage_iq_if #(
  parameter int GRLEN  = 32,
  parameter int HINT_W = 4
);
  logic [2:0]                   valid;
  logic [2:0][GRLEN-1:0]        pc;
  logic [2:0][31:0]             inst;
  logic [2:0][GRLEN-3:0]        br_target;
  logic [2:0]                   br_taken;
  logic [2:0]                   exception;
  logic [2:0][5:0]              exccode;
  logic [2:0][HINT_W-1:0]       hint;
  logic                         ready;

  modport master (
    output valid, pc, inst, br_target, br_taken, exception, exccode, hint,
    input  ready
  );

  modport slave (
    input  valid, pc, inst, br_target, br_taken, exception, exccode, hint,
    output ready
  );
endinterface

// File: rtl/lsoc1000_stage_iq.sv
// ---------------------------------------------------------------------------
// lsoc1000_stage_iq
// 3-wide circular instruction queue between fetch and de1. Up to three
// fetched instructions (contiguous valid prefix of the fetch bundle) are
// written per cycle; the oldest three queued entries are presented to de1 in
// program order. A flush drops all queued entries and the current fetch
// bundle.
// Ports:
//   clk    : clock, rising edge
//   resetn : asynchronous active-low reset (empties queue, zeroes entries)
//   flush  : discard all entries and this cycle's fetch bundle
//   fe     : fetch bundle in; fe.ready is fe_allow_in (room for 3)
//   de1    : oldest three entries out; de1.ready is allow_in from de1
// QDEPTH must be a power of two and at least 4.
// ---------------------------------------------------------------------------
module lsoc1000_stage_iq #(
  parameter int QDEPTH          = 8,
  parameter int GRLEN           = 32,
  parameter int LSOC1K_PRU_HINT = 3
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 flush,
  lsoc1000_stage_iq_if.slave   fe,
  lsoc1000_stage_iq_if.master  de1
);

  localparam int PW     = $clog2(QDEPTH);
  localparam int CW     = PW + 1;
  localparam int HINT_W = LSOC1K_PRU_HINT + 1;

  // entry storage
  logic [GRLEN-1:0]  r_pc        [QDEPTH];
  logic [31:0]       r_inst      [QDEPTH];
  logic [GRLEN-3:0]  r_br_target [QDEPTH];
  logic              r_br_taken  [QDEPTH];
  logic              r_exception [QDEPTH];
  logic [5:0]        r_exccode   [QDEPTH];
  logic [HINT_W-1:0] r_hint      [QDEPTH];

  logic [PW-1:0]     r_head;
  logic [PW-1:0]     r_tail;
  logic [CW-1:0]     r_count;

  logic [1:0]        w_n_in;
  logic [1:0]        w_n_in_eff;
  logic [1:0]        w_n_out;
  logic [CW-1:0]     w_free;
  logic              w_fe_allow;
  logic              w_enq;
  logic [CW-1:0]     w_count_next;
  logic [PW-1:0]     w_widx [3];

  // enqueue count: length of the contiguous valid prefix from slot 0
  always_comb begin
    w_n_in = 2'd0;
    case (fe.valid)
      3'b111:         w_n_in = 2'd3;
      3'b011:         w_n_in = 2'd2;
      3'b001, 3'b101: w_n_in = 2'd1;
      default:        w_n_in = 2'd0;
    endcase
  end

  // admission: only registered occupancy decides, never allow_in/flush
  always_comb begin
    w_free     = CW'(QDEPTH) - r_count;
    w_fe_allow = (w_free >= CW'(3));
    w_enq      = w_fe_allow & ~flush;
    if (w_enq) begin
      w_n_in_eff = w_n_in;
    end else begin
      w_n_in_eff = 2'd0;
    end
  end

  // dequeue count: min(count,3) when de1 accepts and no flush
  always_comb begin
    w_n_out = 2'd0;
    if (de1.ready && !flush) begin
      if (r_count >= CW'(3)) begin
        w_n_out = 2'd3;
      end else begin
        w_n_out = r_count[1:0];
      end
    end else begin
      w_n_out = 2'd0;
    end
  end

  // next occupancy and write slot indices (wrap naturally modulo QDEPTH)
  always_comb begin
    w_count_next = r_count + CW'(w_n_in_eff) - CW'(w_n_out);
    for (int j = 0; j < 3; j++) begin
      w_widx[j] = r_tail + PW'(j);
    end
  end

  // pointer and occupancy registers; flush overrides enqueue and dequeue
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PW'(w_n_out);
      r_tail  <= r_tail + PW'(w_n_in_eff);
      r_count <= w_count_next;
    end
  end

  // entry writes; admission guarantees the three target slots are free,
  // so a write never lands on an entry being presented this cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < QDEPTH; i++) begin
        r_pc[i]        <= '0;
        r_inst[i]      <= '0;
        r_br_target[i] <= '0;
        r_br_taken[i]  <= 1'b0;
        r_exception[i] <= 1'b0;
        r_exccode[i]   <= '0;
        r_hint[i]      <= '0;
      end
    end else begin
      for (int j = 0; j < 3; j++) begin
        if (w_enq && (2'(j) < w_n_in)) begin
          r_pc[w_widx[j]]        <= fe.pc[j];
          r_inst[w_widx[j]]      <= fe.inst[j];
          r_br_target[w_widx[j]] <= fe.br_target[j];
          r_br_taken[w_widx[j]]  <= fe.br_taken[j];
          r_exception[w_widx[j]] <= fe.exception[j];
          r_exccode[w_widx[j]]   <= fe.exccode[j];
          r_hint[w_widx[j]]      <= fe.hint[j];
        end
      end
    end
  end

  assign fe.ready = w_fe_allow;

  // presentation: entry head+k; payload is driven even when not valid
  for (genvar k = 0; k < 3; k++) begin : g_port
    logic [PW-1:0] w_ridx;
    assign w_ridx              = r_head + PW'(k);
    assign de1.valid[k]        = (r_count > CW'(k)) & ~flush;
    assign de1.pc[k]           = r_pc[w_ridx];
    assign de1.inst[k]         = r_inst[w_ridx];
    assign de1.br_target[k]    = r_br_target[w_ridx];
    assign de1.br_taken[k]     = r_br_taken[w_ridx];
    assign de1.exception[k]    = r_exception[w_ridx];
    assign de1.exccode[k]      = r_exccode[w_ridx];
    assign de1.hint[k]         = r_hint[w_ridx];
  end

endmodule
